// File: rtl/mem_xfer_if.sv
// Bundle between the CPU sequencer, the transfer engine and the single-port mem.
// The master side is the transfer engine; the slave side is the CPU plus memory.
interface mem_xfer_if #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 8,
   parameter int LEN_W  = 8
);
   logic              start;
   logic [1:0]        mode;
   logic [ADDR_W-1:0] src;
   logic [ADDR_W-1:0] dest;
   logic [LEN_W-1:0]  count;
   logic [DATA_W-1:0] fill_word;
   logic              busy;
   logic              done;
   logic              collision;
   logic              mem_read;
   logic [ADDR_W-1:0] mem_read_idx;
   logic [DATA_W-1:0] mem_read_byte;
   logic              mem_read_ack;
   logic              mem_write;
   logic [ADDR_W-1:0] mem_write_idx;
   logic [DATA_W-1:0] mem_write_byte;

   modport master (
      input  start, mode, src, dest, count, fill_word, mem_read_byte, mem_read_ack,
      output busy, done, collision, mem_read, mem_read_idx, mem_write, mem_write_idx,
             mem_write_byte
   );

   modport slave (
      output start, mode, src, dest, count, fill_word, mem_read_byte, mem_read_ack,
      input  busy, done, collision, mem_read, mem_read_idx, mem_write, mem_write_idx,
             mem_write_byte
   );
endinterface

// File: rtl/mem_xfer.sv
// Block-move engine for the CHIP-8 core: COPY, FILL and collision-reporting XOR blits
// over the single-port mem interface, owning the bus only while busy.
module mem_xfer #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 8,
   parameter int LEN_W  = 8
) (
   input logic        clk,
   input logic        reset,
   mem_xfer_if.master bus
);
   typedef enum logic [1:0] {IDLE, RD_SRC, RD_DST, WR} state_t;

   localparam logic [1:0] MODE_FILL = 2'd1;
   localparam logic [1:0] MODE_XOR  = 2'd2;

   state_t            state, state_nx;
   logic [1:0]        mode_q;
   logic [ADDR_W-1:0] src_q, dest_q;
   logic [LEN_W-1:0]  count_q, idx;
   logic [DATA_W-1:0] fill_q, s_q, d_q;
   logic              done_q, coll_q;
   logic              accept, last, lat_s, lat_d, rd_req, wr_req;

   function automatic logic [DATA_W-1:0] wr_data(input logic [1:0] m,
                                                 input logic [DATA_W-1:0] s,
                                                 input logic [DATA_W-1:0] d,
                                                 input logic [DATA_W-1:0] f);
      case (m)
         MODE_FILL: return f;
         MODE_XOR:  return s ^ d;
         default:   return s;
      endcase
   endfunction

   // Reads rely on mem acking exactly one cycle later; the request drops in the ack cycle.
   always_comb begin
      state_nx = state;
      accept   = 1'b0;
      lat_s    = 1'b0;
      lat_d    = 1'b0;
      rd_req   = 1'b0;
      wr_req   = 1'b0;
      last     = (idx == count_q);
      case (state)
         IDLE: begin
            if (bus.start) begin
               accept   = 1'b1;
               state_nx = (bus.mode == MODE_FILL) ? WR : RD_SRC;
            end
         end
         RD_SRC: begin
            if (bus.mem_read_ack) begin
               lat_s    = 1'b1;
               state_nx = (mode_q == MODE_XOR) ? RD_DST : WR;
            end else begin
               rd_req = 1'b1;
            end
         end
         RD_DST: begin
            if (bus.mem_read_ack) begin
               lat_d    = 1'b1;
               state_nx = WR;
            end else begin
               rd_req = 1'b1;
            end
         end
         WR: begin
            wr_req = 1'b1;
            if (last) state_nx = IDLE;
            else      state_nx = (mode_q == MODE_FILL) ? WR : RD_SRC;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         idx    <= '0;
         done_q <= 1'b0;
         coll_q <= 1'b0;
      end else begin
         state  <= state_nx;
         done_q <= (state == WR) && last;
         if (accept) begin
            idx    <= '0;
            coll_q <= 1'b0;
         end else if (state == WR && !last) begin
            idx <= idx + LEN_W'(1);
         end
         if (lat_d && ((s_q & bus.mem_read_byte) != '0)) coll_q <= 1'b1;
      end
   end

   // Operand and data registers carry no reset; they are only consumed while busy.
   always_ff @(posedge clk) begin
      if (accept) begin
         mode_q  <= bus.mode;
         src_q   <= bus.src;
         dest_q  <= bus.dest;
         count_q <= bus.count;
         fill_q  <= bus.fill_word;
      end
      if (lat_s) s_q <= bus.mem_read_byte;
      if (lat_d) d_q <= bus.mem_read_byte;
   end

   assign bus.busy           = (state != IDLE);
   assign bus.done           = done_q;
   assign bus.collision      = coll_q;
   assign bus.mem_read       = rd_req & ~reset;
   assign bus.mem_write      = wr_req & ~reset;
   assign bus.mem_read_idx   = ((state == RD_DST) ? dest_q : src_q) + ADDR_W'(idx);
   assign bus.mem_write_idx  = dest_q + ADDR_W'(idx);
   assign bus.mem_write_byte = wr_data(mode_q, s_q, d_q, fill_q);
endmodule

// File: tb/tb_mem_xfer.sv
// Bench for mem_xfer: memory model with one-cycle read ack, and a write scoreboard
// filled from a reference model when each transfer is launched.
module tb_mem_xfer;
   localparam int ADDR_W = 12;
   localparam int DATA_W = 8;
   localparam int LEN_W  = 8;
   localparam logic [1:0] M_COPY = 2'd0;
   localparam logic [1:0] M_FILL = 2'd1;
   localparam logic [1:0] M_XOR  = 2'd2;

   logic clk = 1'b0;
   logic reset = 1'b1;

   mem_xfer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) bus ();

   mem_xfer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int          n_chk = 0;
   int          n_fail = 0;
   int          n_rd = 0;
   logic [19:0] exp_q[$];
   logic [7:0]  mem [0:4095];
   logic        pl_we = 1'b0;
   logic [11:0] pl_addr = '0;
   logic [7:0]  pl_data = '0;

   logic        hold_start = 1'b0;
   logic [1:0]  nx_mode;
   logic [11:0] nx_src, nx_dest;
   logic [7:0]  nx_count, nx_fill;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Memory: one-cycle registered read ack, writes on the strobe edge.
   always @(posedge clk) begin
      if (pl_we) mem[pl_addr] <= pl_data;
      else if (bus.mem_write) mem[bus.mem_write_idx] <= bus.mem_write_byte;
      bus.mem_read_ack  <= bus.mem_read;
      bus.mem_read_byte <= mem[bus.mem_read_idx];
   end

   always @(negedge clk) begin
      logic [19:0] e;
      if (bus.mem_read) n_rd++;
      if (bus.mem_write) begin
         if (exp_q.size() == 0) begin
            chk("wr_unexpected", 32'(bus.mem_write_idx), 32'hFFFF_FFFF);
         end else begin
            e = exp_q.pop_front();
            chk("wr_addr", 32'(bus.mem_write_idx), 32'(e[19:8]));
            chk("wr_data", 32'(bus.mem_write_byte), 32'(e[7:0]));
         end
      end
   end

   task automatic poke(input logic [11:0] a, input logic [7:0] d);
      pl_addr = a;
      pl_data = d;
      pl_we   = 1'b1;
      @(posedge clk); #1;
      pl_we   = 1'b0;
   endtask

   task automatic push_exp(input logic [1:0] m, input logic [11:0] s, input logic [11:0] dst,
                           input logic [7:0] cnt, input logic [7:0] f, output logic coll);
      logic [11:0] sa, da;
      logic [7:0]  dv;
      coll = 1'b0;
      for (int k = 0; k <= int'(cnt); k++) begin
         sa = s + 12'(k);
         da = dst + 12'(k);
         case (m)
            M_FILL: dv = f;
            M_XOR: begin
               dv = mem[sa] ^ mem[da];
               if ((mem[sa] & mem[da]) != 8'h00) coll = 1'b1;
            end
            default: dv = mem[sa];
         endcase
         exp_q.push_back({da, dv});
      end
   endtask

   task automatic launch(input logic [1:0] m, input logic [11:0] s, input logic [11:0] dst,
                         input logic [7:0] cnt, input logic [7:0] f);
      bus.mode      = m;
      bus.src       = s;
      bus.dest      = dst;
      bus.count     = cnt;
      bus.fill_word = f;
      bus.start     = 1'b1;
   endtask

   task automatic wait_done(input string tag, input int lat, input logic exp_coll, input int q_left);
      for (int k = 1; k <= 400; k++) begin
         @(posedge clk); #1;
         if (k == 1) begin
            if (hold_start) begin
               bus.mode      = nx_mode;
               bus.src       = nx_src;
               bus.dest      = nx_dest;
               bus.count     = nx_count;
               bus.fill_word = nx_fill;
            end else begin
               bus.start = 1'b0;
            end
            chk({tag, "_busy_rise"}, 32'(bus.busy), 32'd1);
            chk({tag, "_coll_clr"}, 32'(bus.collision), 32'd0);
         end
         if (bus.done) begin
            chk({tag, "_latency"}, 32'(k), 32'(lat));
            chk({tag, "_busy_fall"}, 32'(bus.busy), 32'd0);
            chk({tag, "_collision"}, 32'(bus.collision), 32'(exp_coll));
            chk({tag, "_writes_left"}, 32'(exp_q.size()), 32'(q_left));
            return;
         end
      end
      chk({tag, "_done_timeout"}, 32'd0, 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic       ec, ec2;
      int         rd0, acks;
      logic [7:0] pat [4];
      pat = '{8'h11, 8'h22, 8'h33, 8'h44};
      bus.start = 1'b0;
      bus.mode = '0;
      bus.src = '0;
      bus.dest = '0;
      bus.count = '0;
      bus.fill_word = '0;
      repeat (3) @(posedge clk);
      #1;
      bus.start = 1'b1;
      #1;
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk("rst_coll", 32'(bus.collision), 32'd0);
      chk("rst_mem_read", 32'(bus.mem_read), 32'd0);
      chk("rst_mem_write", 32'(bus.mem_write), 32'd0);
      bus.start = 1'b0;
      reset = 1'b0;
      @(posedge clk); #1;

      for (int k = 0; k < 4; k++) poke(12'h020 + 12'(k), pat[k]);
      poke(12'h060, 8'hF0); poke(12'h360, 8'h3C);
      poke(12'h061, 8'hF0); poke(12'h361, 8'h0F);
      poke(12'h040, 8'hA1); poke(12'h041, 8'hA2);
      poke(12'h042, 8'hA3); poke(12'h043, 8'hA4);
      poke(12'h080, 8'h05); poke(12'h081, 8'h06);

      // COPY of four words
      rd0 = n_rd;
      push_exp(M_COPY, 12'h020, 12'h300, 8'd3, 8'h00, ec);
      launch(M_COPY, 12'h020, 12'h300, 8'd3, 8'h00);
      wait_done("copy", 13, ec, 0);
      chk("copy_reads", 32'(n_rd - rd0), 32'd4);
      for (int k = 0; k < 4; k++) chk("copy_mem", 32'(mem[12'h300 + 12'(k)]), 32'(pat[k]));

      // FILL of 256 words
      rd0 = n_rd;
      push_exp(M_FILL, 12'h000, 12'h100, 8'hFF, 8'h00, ec);
      launch(M_FILL, 12'h000, 12'h100, 8'hFF, 8'h00);
      wait_done("fill", 257, ec, 0);
      chk("fill_reads", 32'(n_rd - rd0), 32'd0);

      // XOR with and without collision
      rd0 = n_rd;
      push_exp(M_XOR, 12'h060, 12'h360, 8'd0, 8'h00, ec);
      launch(M_XOR, 12'h060, 12'h360, 8'd0, 8'h00);
      wait_done("xor1", 6, ec, 0);
      chk("xor1_reads", 32'(n_rd - rd0), 32'd2);
      chk("xor1_mem", 32'(mem[12'h360]), 32'hCC);
      chk("xor1_coll_expected", 32'(bus.collision), 32'd1);
      @(posedge clk); #1;
      chk("xor1_done_pulse", 32'(bus.done), 32'd0);
      chk("xor1_coll_sticky", 32'(bus.collision), 32'd1);
      push_exp(M_XOR, 12'h061, 12'h361, 8'd0, 8'h00, ec);
      launch(M_XOR, 12'h061, 12'h361, 8'd0, 8'h00);
      wait_done("xor2", 6, ec, 0);
      chk("xor2_mem", 32'(mem[12'h361]), 32'hFF);

      // FILL wrapping past the top of the address space
      push_exp(M_FILL, 12'h000, 12'hFFE, 8'd2, 8'h5A, ec);
      launch(M_FILL, 12'h000, 12'hFFE, 8'd2, 8'h5A);
      wait_done("wrap", 4, ec, 0);
      chk("wrap_mem0", 32'(mem[12'h000]), 32'h5A);

      // Reset during the second read-ack cycle of a COPY
      exp_q.push_back({12'h340, 8'hA1});
      launch(M_COPY, 12'h040, 12'h340, 8'd3, 8'h00);
      acks = 0;
      for (int k = 1; k <= 40 && acks < 2; k++) begin
         @(posedge clk); #1;
         if (k == 1) bus.start = 1'b0;
         if (bus.mem_read_ack) acks++;
      end
      chk("rstc_acks_seen", 32'(acks), 32'd2);
      reset = 1'b1;
      #1;
      chk("rstc_rd_gate", 32'(bus.mem_read), 32'd0);
      chk("rstc_wr_gate", 32'(bus.mem_write), 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      chk("rstc_busy", 32'(bus.busy), 32'd0);
      chk("rstc_done", 32'(bus.done), 32'd0);
      repeat (5) @(posedge clk);
      #1;
      chk("rstc_writes_left", 32'(exp_q.size()), 32'd0);

      // Restart after reset: single-word COPY
      rd0 = n_rd;
      push_exp(M_COPY, 12'h041, 12'h341, 8'd0, 8'h00, ec);
      launch(M_COPY, 12'h041, 12'h341, 8'd0, 8'h00);
      wait_done("one_word", 4, ec, 0);
      chk("one_word_reads", 32'(n_rd - rd0), 32'd1);
      chk("one_word_mem", 32'(mem[12'h341]), 32'hA2);

      // Reset in a FILL write cycle suppresses that write
      exp_q.push_back({12'h500, 8'h77});
      exp_q.push_back({12'h501, 8'h77});
      launch(M_FILL, 12'h000, 12'h500, 8'd9, 8'h77);
      @(posedge clk); #1;
      bus.start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b1;
      #1;
      chk("rstf_wr_gate", 32'(bus.mem_write), 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      chk("rstf_busy", 32'(bus.busy), 32'd0);
      repeat (4) @(posedge clk);
      #1;
      chk("rstf_writes_left", 32'(exp_q.size()), 32'd0);

      // Back-to-back: start held high, operands changed while busy
      push_exp(M_COPY, 12'h080, 12'h380, 8'd1, 8'h00, ec);
      push_exp(M_FILL, 12'h000, 12'h400, 8'd3, 8'hA5, ec2);
      nx_mode = M_FILL; nx_src = 12'h000; nx_dest = 12'h400; nx_count = 8'd3; nx_fill = 8'hA5;
      hold_start = 1'b1;
      launch(M_COPY, 12'h080, 12'h380, 8'd1, 8'h00);
      wait_done("b2b_a", 7, ec, 4);
      hold_start = 1'b0;
      wait_done("b2b_b", 5, ec2, 0);
      chk("b2b_mem0", 32'(mem[12'h380]), 32'h05);
      chk("b2b_mem1", 32'(mem[12'h381]), 32'h06);
      chk("b2b_fill", 32'(mem[12'h403]), 32'hA5);

      repeat (3) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/mem_xfer.md
# mem_xfer

Parametrised memory transfer engine for the CHIP-8 core. It takes over the block-move work the CPU sequences by hand: register save/restore (Fx55/Fx65), screen clear (00E0) and sprite blits into the screen region. It adds three capabilities the CPU sequencer lacks: configurable address, data and length widths; a fill mode; and an XOR-blit mode that reports collisions. It sits between the CPU state machine and the single-port `mem` read/write interface, and owns the bus only while `busy` is high.

## Interface
- `ADDR_W`, 12: memory address width. All addresses wrap modulo 2^ADDR_W.
- `DATA_W`, 8: memory data width.
- `LEN_W`, 8: length field width. A transfer moves up to 2^LEN_W words.
- `clk` in 1: system clock. One clock domain.
- `reset` in 1: reset, synchronous and active-high.
- `start` in ADDR_W-independent 1: request a transfer. Sampled only when `busy`=0.
- `mode` in 2: transfer mode. 0 = COPY, 1 = FILL, 2 = XOR, 3 = reserved (behaves as COPY).
- `src` in ADDR_W: source base address. Ignored in FILL.
- `dest` in ADDR_W: destination base address.
- `count` in LEN_W: number of words minus one.
- `fill_word` in DATA_W: value written in FILL mode.
- `busy` out 1: transfer in progress.
- `done` out 1: one-cycle pulse on completion.
- `collision` out 1: sticky flag. Set by XOR when any destination bit goes 1→0.
- `mem_read` out 1: read request.
- `mem_read_idx` out ADDR_W: read address.
- `mem_read_byte` in DATA_W: read data, valid with ack.
- `mem_read_ack` in 1: read acknowledge. Arrives the cycle after the request.
- `mem_write` out 1: single-cycle write strobe.
- `mem_write_idx` out ADDR_W: write address.
- `mem_write_byte` out DATA_W: write data.

## Operation
- States: IDLE, RD_SRC, RD_DST, WR.
- Start (IDLE, `start`=1):
  - Latch `mode`, `src`, `dest`, `count`, `fill_word`.
  - Clear the index `i` and `collision`.
  - Next state: FILL → WR; any other mode → RD_SRC.
- RD_SRC:
  - `mem_read`=1 and `mem_read_idx`=`src`+i while `mem_read_ack`=0.
  - On ack: latch data as `s`; next state RD_DST if XOR, else WR.
- RD_DST (XOR only):
  - Read `dest`+i using the same handshake.
  - On ack: latch `d`; if (`s` & `d`)≠0, set `collision`; next state WR.
- WR:
  - `mem_write`=1, `mem_write_idx`=`dest`+i.
  - Write data: COPY → `s`; FILL → `fill_word`; XOR → `s`^`d`.
  - If `i`==`count`: next state IDLE and pulse `done`.
  - Otherwise: `i`←`i`+1; next state WR (FILL) or RD_SRC.
- Addresses advance in ascending order from the base. Address sums are ADDR_W bits and wrap silently (0xFFF+1 → 0x000 when ADDR_W=12).
- `count`=0 moves exactly one word. `count`=2^LEN_W−1 moves 2^LEN_W words. The index never wraps.
- `mem_read`/`mem_write` are combinational from state and ack, and are 0 in IDLE. In IDLE the CPU may use the bus freely, and any `mem_read_ack` seen in IDLE is ignored.
- `start` while `busy`=1 is ignored. Operands stay as latched.
- `collision` holds its value after `done` until the next accepted `start`.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `collision`=0, `i`=0. `mem_read` and `mem_write` are forced to 0 during every cycle in which `reset`=1.
- Reset mid-transfer: abandon immediately. No write occurs in the reset cycle or after it. A late ack for an outstanding read is ignored.
- `busy` rises in the cycle after `start` is accepted and falls in the same cycle `done` pulses, which is the cycle after the final WR.
- Cost per word: COPY 3 cycles (request, ack, write); FILL 1 cycle; XOR 5 cycles.
- Total latency from the `start` cycle to the `done` cycle is (count+1)×per-word+1 cycles. For example, a 1-word COPY pulses `done` 4 cycles after `start`.
- `start` asserted in the same cycle as `done` is accepted, giving back-to-back transfers with no idle gap.
- The read handshake relies on `mem` acking exactly one cycle after the request. The request must drop in the ack cycle so that only one read is issued per word.

## Test plan
- COPY: `src`=0x020, `dest`=0x300, `count`=3, memory 0x020..0x023 = 11,22,33,44 → 0x300..0x303 hold 11,22,33,44. Writes are ascending, `done` pulses at cycle 13, `collision`=0.
- FILL: `dest`=0x100, `count`=0xFF, `fill_word`=0 → 256 consecutive single-cycle writes to 0x100..0x1FF, `done` pulses at cycle 257, no reads are issued.
- XOR: `src` word 0xF0 onto `dest` word 0x3C → `dest` becomes 0xCC and `collision`=1. Re-run with `dest`=0x0F → result 0xFF and `collision`=0.
- Wrap and limits: `dest`=0xFFE, `count`=2, FILL → writes go to 0xFFE, 0xFFF, 0x000. `count`=0 in COPY → exactly one write.
- Reset mid-COPY: assert `reset` during the RD_SRC ack cycle of word 2 → no further writes, `busy`=0 the next cycle, and a new `start` afterwards completes normally.
- Back-to-back: hold `start` high through `done` → the second transfer begins in the `done` cycle, while `start` pulses during `busy` are ignored.
